// File: rtl/load_store_queue.sv
// Unified in-order load/store queue feeding a single request/grant data-memory port.
// Entries are issued strictly in push order; loads wait for read data and produce a
// one-cycle write-back strobe, misaligned entries are dropped with a one-cycle flag.
module load_store_queue #(
    parameter int unsigned C_XLEN  = 32,
    parameter int unsigned C_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic              ex_lq_wr_i,
    input  logic              ex_sq_wr_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [4:0]        ex_regd_addr_i,
    input  logic [C_XLEN-1:0] ex_regs2_data_i,
    input  logic [C_XLEN-1:0] ex_addr_i,
    output logic              lq_full_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [C_XLEN-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [C_XLEN-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [C_XLEN-1:0] dmem_rdata_i,
    output logic              wb_regd_wr_o,
    output logic [4:0]        wb_regd_addr_o,
    output logic [C_XLEN-1:0] wb_regd_data_o,
    output logic              misalign_o
);

    localparam int unsigned PTR_W = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              is_store;
        logic [2:0]        funct3;
        logic [4:0]        regd;
        logic [C_XLEN-1:0] data;
        logic [C_XLEN-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2
    } state_e;

    entry_t            mem_q [C_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q,  count_d;
    state_e            state_q,  state_d;
    logic              wb_wr_q;
    logic [4:0]        wb_addr_q;
    logic [C_XLEN-1:0] wb_data_q;
    logic              misalign_q;

    entry_t            head_c;
    entry_t            new_entry_c;
    logic              full_c;
    logic              push_c;
    logic              pop_c;
    logic              more_c;
    logic              head_misalign_c;
    logic              wb_fire_c;
    logic              misalign_fire_c;
    logic [3:0]        be_c;
    logic [C_XLEN-1:0] wdata_c;
    logic [C_XLEN-1:0] rd_shift_c;
    logic [C_XLEN-1:0] load_data_c;

    assign head_c  = mem_q[rd_ptr_q];
    assign full_c  = (count_q == CNT_W'(C_DEPTH));
    assign push_c  = clk_en_i & (ex_lq_wr_i | ex_sq_wr_i) & ~full_c;
    // Entries remaining after the current pop (a simultaneous push keeps the queue busy)
    assign more_c  = (count_q > CNT_W'(1)) | push_c;

    assign new_entry_c.is_store = ex_sq_wr_i;
    assign new_entry_c.funct3   = ex_funct3_i;
    assign new_entry_c.regd     = ex_regd_addr_i;
    assign new_entry_c.data     = ex_regs2_data_i;
    assign new_entry_c.addr     = ex_addr_i;

    // Head-entry alignment check, byte enables and lane-replicated store data
    always_comb begin
        head_misalign_c = 1'b0;
        be_c            = 4'b1111;
        wdata_c         = head_c.data;
        case (head_c.funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << head_c.addr[1:0];
                wdata_c = {(C_XLEN/8){head_c.data[7:0]}};
            end
            2'b01: begin
                head_misalign_c = head_c.addr[0];
                be_c            = head_c.addr[1] ? 4'b1100 : 4'b0011;
                wdata_c         = {(C_XLEN/16){head_c.data[15:0]}};
            end
            default: begin
                head_misalign_c = (head_c.addr[1:0] != 2'b00);
            end
        endcase
    end

    // Lane extraction and sign/zero extension of returned load data
    always_comb begin
        rd_shift_c  = dmem_rdata_i >> {head_c.addr[1:0], 3'b000};
        load_data_c = rd_shift_c;
        case (head_c.funct3)
            3'b000:  load_data_c = {{(C_XLEN-8){rd_shift_c[7]}},   rd_shift_c[7:0]};
            3'b001:  load_data_c = {{(C_XLEN-16){rd_shift_c[15]}}, rd_shift_c[15:0]};
            3'b100:  load_data_c = {{(C_XLEN-8){1'b0}},            rd_shift_c[7:0]};
            3'b101:  load_data_c = {{(C_XLEN-16){1'b0}},           rd_shift_c[15:0]};
            default: load_data_c = rd_shift_c;
        endcase
    end

    // Issue FSM: next state, pop and strobe decisions for the head entry
    always_comb begin
        state_d         = state_q;
        pop_c           = 1'b0;
        wb_fire_c       = 1'b0;
        misalign_fire_c = 1'b0;
        if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if ((count_q != '0) || push_c) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (head_misalign_c) begin
                        pop_c           = 1'b1;
                        misalign_fire_c = 1'b1;
                        state_d         = more_c ? S_REQ : S_IDLE;
                    end else if (dmem_gnt_i) begin
                        if (head_c.is_store) begin
                            pop_c   = 1'b1;
                            state_d = more_c ? S_REQ : S_IDLE;
                        end else begin
                            state_d = S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (dmem_rvalid_i) begin
                        pop_c     = 1'b1;
                        wb_fire_c = (head_c.regd != 5'd0);
                        state_d   = more_c ? S_REQ : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Occupancy update
    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, pointers and registered strobes
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_wr_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else if (clk_en_i) begin
            state_q    <= state_d;
            count_q    <= count_d;
            wb_wr_q    <= wb_fire_c;
            misalign_q <= misalign_fire_c;
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wb_fire_c) begin
                wb_addr_q <= head_c.regd;
                wb_data_q <= load_data_c;
            end
        end
    end

    // Entry storage; contents beyond the valid window are don't-care
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_c) begin
            mem_q[wr_ptr_q] <= new_entry_c;
        end
    end

    assign lq_full_o      = full_c & ~reset_i;
    assign dmem_req_o     = (state_q == S_REQ) & ~head_misalign_c & ~reset_i;
    assign dmem_we_o      = dmem_req_o & head_c.is_store;
    assign dmem_addr_o    = {head_c.addr[C_XLEN-1:2], 2'b00};
    assign dmem_be_o      = be_c;
    assign dmem_wdata_o   = wdata_c;
    assign wb_regd_wr_o   = wb_wr_q & ~reset_i;
    assign wb_regd_addr_o = wb_addr_q;
    assign wb_regd_data_o = wb_data_q;
    assign misalign_o     = misalign_q & ~reset_i;

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed scenarios followed by randomized traffic
// checked against a transaction-level queue model.
module tb_load_store_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset_i, clk_en_i;
    logic            ex_lq_wr_i, ex_sq_wr_i;
    logic [2:0]      ex_funct3_i;
    logic [4:0]      ex_regd_addr_i;
    logic [XLEN-1:0] ex_regs2_data_i, ex_addr_i;
    logic            lq_full_o, dmem_req_o, dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]      dmem_be_o;
    logic            dmem_gnt_i, dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;
    logic            wb_regd_wr_o;
    logic [4:0]      wb_regd_addr_o;
    logic [XLEN-1:0] wb_regd_data_o;
    logic            misalign_o;

    int errors = 0;
    int checks = 0;

    load_store_queue #(.C_XLEN(XLEN), .C_DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i),
        .ex_funct3_i(ex_funct3_i), .ex_regd_addr_i(ex_regd_addr_i),
        .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
        .lq_full_o(lq_full_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_regd_wr_o(wb_regd_wr_o), .wb_regd_addr_o(wb_regd_addr_o),
        .wb_regd_data_o(wb_regd_data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [4:0]  rd;
        bit [31:0] data;
        bit [31:0] addr;
    } ent_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_push(input bit st, input bit [2:0] f3, input bit [4:0] rd,
                              input bit [31:0] data, input bit [31:0] addr);
        ex_sq_wr_i      = st;
        ex_lq_wr_i      = ~st;
        ex_funct3_i     = f3;
        ex_regd_addr_i  = rd;
        ex_regs2_data_i = data;
        ex_addr_i       = addr;
    endtask

    task automatic no_push();
        ex_sq_wr_i = 1'b0;
        ex_lq_wr_i = 1'b0;
    endtask

    function automatic logic [3:0] f_be(input bit [2:0] f3, input bit [31:0] a);
        int off;
        off = int'(a % 4);
        if (f3[1:0] == 2'd0) return 4'(1 << off);
        if (f3[1:0] == 2'd1) return (off < 2) ? 4'h3 : 4'hC;
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input bit [2:0] f3, input bit [31:0] d);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] r);
        bit [31:0] v;
        v = r >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        ent_t      q[$];
        ent_t      e;
        bit        outstanding, exp_wb, exp_req, en, gnt, rv, push, accept, nwb;
        bit [4:0]  exp_wb_addr, nwb_addr;
        bit [31:0] exp_wb_data, nwb_data, rdata;
        bit [31:0] tx_addr[$];
        int        n_req, n_mis, n_wb;
        bit [2:0]  ld_f3[5];

        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        reset_i = 1'b1; clk_en_i = 1'b1; no_push();
        ex_funct3_i = '0; ex_regd_addr_i = '0; ex_regs2_data_i = '0; ex_addr_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

        // Reset state
        tick(); settle();
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_full", 32'(lq_full_o), 32'd0);
        chk("rst_wb", 32'(wb_regd_wr_o), 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);
        tick(); reset_i = 1'b0;

        // SW issued one cycle after push, queue empty afterwards
        dmem_gnt_i = 1'b1;
        drive_push(1'b1, 3'd2, 5'd0, 32'hDEAD_BEEF, 32'h100);
        tick(); no_push(); settle();
        chk("sw_req", 32'(dmem_req_o), 32'd1);
        chk("sw_we", 32'(dmem_we_o), 32'd1);
        chk("sw_be", 32'(dmem_be_o), 32'hF);
        chk("sw_addr", dmem_addr_o, 32'h100);
        chk("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
        tick(); settle();
        chk("sw_done_req", 32'(dmem_req_o), 32'd0);

        // LB and LBU of byte 3 returning 0x80
        for (int k = 0; k < 2; k++) begin
            drive_push(1'b0, (k == 0) ? 3'd0 : 3'd4, 5'd5, 32'h0, 32'h203);
            tick(); no_push(); settle();
            chk("lb_req", 32'(dmem_req_o), 32'd1);
            chk("lb_we", 32'(dmem_we_o), 32'd0);
            chk("lb_be", 32'(dmem_be_o), 32'h8);
            chk("lb_addr", dmem_addr_o, 32'h200);
            tick();
            dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8011_2233; settle();
            chk("lb_wait_req", 32'(dmem_req_o), 32'd0);
            tick(); dmem_rvalid_i = 1'b0; settle();
            chk("lb_wb", 32'(wb_regd_wr_o), 32'd1);
            chk("lb_wb_addr", 32'(wb_regd_addr_o), 32'd5);
            chk("lb_wb_data", wb_regd_data_o, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            tick(); settle();
            chk("lb_wb_end", 32'(wb_regd_wr_o), 32'd0);
        end

        // Fill while stalled, drop a push when full, then drain in order
        dmem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, 3'd2, 5'd0, 32'(i), 32'h10 + 32'(4 * i));
            tick();
        end
        drive_push(1'b1, 3'd2, 5'd0, 32'h55, 32'h50); settle();
        chk("fill_full", 32'(lq_full_o), 32'd1);
        tick(); no_push(); settle();
        chk("drop_full", 32'(lq_full_o), 32'd1);
        dmem_gnt_i = 1'b1; settle();
        tx_addr.delete();
        for (int i = 0; i < 8; i++) begin
            if (dmem_req_o) tx_addr.push_back(dmem_addr_o);
            tick(); settle();
        end
        chk("drain_count", 32'(tx_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < tx_addr.size()) chk("drain_order", tx_addr[i], 32'h10 + 32'(4 * i));
        end
        chk("drain_full", 32'(lq_full_o), 32'd0);

        // Misaligned LW discarded with a single flag cycle
        drive_push(1'b0, 3'd2, 5'd3, 32'h0, 32'h102);
        tick(); no_push();
        n_req = 0; n_mis = 0; n_wb = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_req += int'(dmem_req_o); n_mis += int'(misalign_o); n_wb += int'(wb_regd_wr_o);
            tick();
        end
        chk("mis_req", 32'(n_req), 32'd0);
        chk("mis_flag", 32'(n_mis), 32'd1);
        chk("mis_wb", 32'(n_wb), 32'd0);

        // Reset while a load is outstanding with a second entry queued
        drive_push(1'b0, 3'd2, 5'd7, 32'h0, 32'h300);
        tick();
        drive_push(1'b1, 3'd2, 5'd0, 32'h1234, 32'h304);
        tick(); no_push();
        reset_i = 1'b1; clk_en_i = 1'b0; settle();
        chk("rwait_req", 32'(dmem_req_o), 32'd0);
        chk("rwait_wb", 32'(wb_regd_wr_o), 32'd0);
        chk("rwait_full", 32'(lq_full_o), 32'd0);
        tick(); reset_i = 1'b0; clk_en_i = 1'b1; settle();
        chk("rpost_req", 32'(dmem_req_o), 32'd0);
        chk("rpost_full", 32'(lq_full_o), 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
        tick(); dmem_rvalid_i = 1'b0; settle();
        chk("rpost_wb", 32'(wb_regd_wr_o), 32'd0);
        chk("rpost_req2", 32'(dmem_req_o), 32'd0);

        // Clock enable low freezes a pending request despite grant
        dmem_gnt_i = 1'b0;
        drive_push(1'b1, 3'd2, 5'd0, 32'h1234_5678, 32'h400);
        tick(); no_push(); settle();
        chk("ce_req0", 32'(dmem_req_o), 32'd1);
        clk_en_i = 1'b0; dmem_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("ce_hold_req", 32'(dmem_req_o), 32'd1);
            chk("ce_hold_addr", dmem_addr_o, 32'h400);
            chk("ce_hold_wdata", dmem_wdata_o, 32'h1234_5678);
        end
        tick(); clk_en_i = 1'b1; settle();
        chk("ce_resume_req", 32'(dmem_req_o), 32'd1);
        tick(); settle();
        chk("ce_done_req", 32'(dmem_req_o), 32'd0);

        // Randomized traffic against a queue model, then a bounded drain
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        q.delete(); outstanding = 1'b0; exp_wb = 1'b0; exp_wb_addr = '0; exp_wb_data = '0;
        for (int c = 0; c < 460; c++) begin
            if (c < 400) begin
                en   = ($urandom_range(0, 9) != 0);
                gnt  = bit'($urandom_range(0, 1));
                push = ($urandom_range(0, 2) == 0);
                rv   = outstanding && ($urandom_range(0, 2) == 0);
            end else begin
                en = 1'b1; gnt = 1'b1; push = 1'b0; rv = outstanding;
            end
            e.st   = bit'($urandom_range(0, 1));
            e.f3   = e.st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            e.rd   = 5'($urandom_range(0, 31));
            e.data = $urandom;
            e.addr = $urandom;
            if (e.f3[1:0] == 2'd1) e.addr[0] = 1'b0;
            if (e.f3[1] == 1'b1) e.addr[1:0] = 2'b00;
            rdata = $urandom;
            clk_en_i = en; dmem_gnt_i = gnt; dmem_rvalid_i = rv; dmem_rdata_i = rdata;
            if (push) drive_push(e.st, e.f3, e.rd, e.data, e.addr); else no_push();
            settle();

            exp_req = (q.size() > 0) && !outstanding;
            chk("rnd_full", 32'(lq_full_o), 32'(q.size() == DEPTH));
            chk("rnd_req", 32'(dmem_req_o), 32'(exp_req));
            if (exp_req && dmem_req_o) begin
                chk("rnd_addr", dmem_addr_o, q[0].addr & 32'hFFFF_FFFC);
                chk("rnd_we", 32'(dmem_we_o), 32'(q[0].st));
                chk("rnd_be", 32'(dmem_be_o), 32'(f_be(q[0].f3, q[0].addr)));
                if (q[0].st) chk("rnd_wdata", dmem_wdata_o, f_wdata(q[0].f3, q[0].data));
            end
            chk("rnd_wb", 32'(wb_regd_wr_o), 32'(exp_wb));
            if (exp_wb) begin
                chk("rnd_wb_addr", 32'(wb_regd_addr_o), 32'(exp_wb_addr));
                chk("rnd_wb_data", wb_regd_data_o, exp_wb_data);
            end
            chk("rnd_mis", 32'(misalign_o), 32'd0);

            if (en) begin
                accept = push && (q.size() < DEPTH);
                nwb = 1'b0; nwb_addr = exp_wb_addr; nwb_data = exp_wb_data;
                if (outstanding && rv) begin
                    nwb      = (q[0].rd != 5'd0);
                    nwb_addr = q[0].rd;
                    nwb_data = f_load(q[0].f3, q[0].addr, rdata);
                    if (!nwb) begin nwb_addr = exp_wb_addr; nwb_data = exp_wb_data; end
                    void'(q.pop_front());
                    outstanding = 1'b0;
                end else if (exp_req && gnt) begin
                    if (q[0].st) void'(q.pop_front());
                    else outstanding = 1'b1;
                end
                if (accept) q.push_back(e);
                exp_wb = nwb; exp_wb_addr = nwb_addr; exp_wb_data = nwb_data;
            end
            tick();
        end
        no_push(); dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; settle();
        chk("end_req", 32'(dmem_req_o), 32'd0);
        chk("end_full", 32'(lq_full_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 Parameter C_XLEN, default 32, sets the data and address width.
REQ-002 Parameter C_DEPTH, default 4 (power of two, 2..16), sets the number of queue entries.
REQ-003 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  reset, synchronous and active-high.
REQ-005 clk_en_i  in  1  global clock enable; when 0, no state updates and bus inputs are ignored.
REQ-006 ex_lq_wr_i / ex_sq_wr_i  in  1 each  push a load or store entry from execute; never both high together.
REQ-007 ex_funct3_i  in  3  RV32I load/store funct3.
REQ-008 ex_regd_addr_i  in  5  load destination register.
REQ-009 ex_regs2_data_i  in  C_XLEN  store data.
REQ-010 ex_addr_i  in  C_XLEN  effective byte address.
REQ-011 lq_full_o  out  1  queue full; execute must not push.
REQ-012 dmem_req_o, dmem_we_o  out  1 each  bus request and write-enable.
REQ-013 dmem_addr_o  out  C_XLEN  word-aligned address {addr[31:2],2'b00}.
REQ-014 dmem_be_o  out  4  byte enables.
REQ-015 dmem_wdata_o  out  C_XLEN  lane-aligned store data.
REQ-016 dmem_gnt_i  in  1  bus accepts the request this cycle.
REQ-017 dmem_rvalid_i  in  1  read data valid.
REQ-018 dmem_rdata_i  in  C_XLEN  read data.
REQ-019 wb_regd_wr_o  out  1  one-cycle load write-back strobe.
REQ-020 wb_regd_addr_o  out  5  write-back register address.
REQ-021 wb_regd_data_o  out  C_XLEN  write-back data.
REQ-022 misalign_o  out  1  one-cycle strobe when a misaligned entry is discarded.

Function
REQ-023 The queue is a single in-order FIFO holding both loads and stores; memory order equals push order.
REQ-024 Pushes are accepted only when clk_en_i=1 and count<C_DEPTH.
REQ-025 A push while full is dropped and leaves the queue unchanged, including in a cycle where a pop also occurs.
REQ-026 lq_full_o = (count==C_DEPTH), combinational from registered count.
REQ-027 Pointers wrap modulo C_DEPTH; count changes by +1 on push only, -1 on pop only, and 0 on push plus pop.
REQ-028 The FSM has states IDLE, REQ and WAIT_RD.
REQ-029 IDLE -> REQ when the queue is non-empty; with an empty queue, an entry pushed in cycle N drives dmem_req_o=1 in cycle N+1.
REQ-030 In REQ, dmem_req_o=1 and the address, we, be and wdata are held stable until dmem_gnt_i=1.
REQ-031 On grant of a store, the entry pops and the FSM goes to IDLE, or stays in REQ if another entry is present.
REQ-032 On grant of a load, the FSM goes to WAIT_RD with dmem_req_o=0.
REQ-033 In WAIT_RD, dmem_rvalid_i=1 in cycle M pops the entry and drives wb_regd_wr_o=1 with its data/addr in cycle M+1; the FSM then proceeds as in REQ-031.
REQ-034 Byte enables: SB/LB/LBU = 1<<addr[1:0]; SH/LH/LHU = 0011 when addr[1]=0, else 1100; SW/LW = 1111.
REQ-035 Store data is replicated across lanes: SB byte x4, SH half x2, SW unchanged.
REQ-036 Load data is extracted by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-037 Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned: no bus request, entry popped, misalign_o=1 for one cycle, no write-back.
REQ-038 A load with regd_addr=0 still performs the bus read, but wb_regd_wr_o stays 0.
REQ-039 When clk_en_i=0, all state and outputs hold and dmem_gnt_i/dmem_rvalid_i are ignored.

Reset
REQ-040 While reset_i=1 at a clock edge, pointers, count and FSM (IDLE) clear and all queued entries are discarded, including one outstanding in WAIT_RD.
REQ-041 While in reset, dmem_req_o=0, wb_regd_wr_o=0, misalign_o=0 and lq_full_o=0.
REQ-042 Reset takes effect regardless of clk_en_i.

Verification
REQ-043 Push SW addr 0x100, data 0xDEADBEEF, gnt tied 1 -> next cycle req=1, we=1, be=1111, addr=0x100, wdata=0xDEADBEEF; queue empty after.
REQ-044 Push LB addr 0x203, x5; rvalid with rdata 0x80112233 -> one cycle later wb_regd_wr_o=1, addr=5, data=0xFFFFFF80; LBU gives 0x00000080.
REQ-045 Push 4 entries with gnt=0 -> lq_full_o=1; 5th push dropped; release gnt -> 4 bus transactions in push order.
REQ-046 Push LW addr 0x102 -> no dmem_req_o, misalign_o=1 for one cycle, no write-back.
REQ-047 Assert reset_i during WAIT_RD with 2 entries queued -> next cycle IDLE, lq_full_o=0, and a later rvalid produces no write-back.
REQ-048 Hold clk_en_i=0 for 3 cycles in REQ while gnt=1 -> outputs frozen and no pop; the transaction completes after clk_en_i returns to 1.
